// File: rtl/bcd_count_sequencer.sv
// bcd_count_sequencer
//
// Command-driven front end for a cascaded BCD up/down counter. A command is taken over a
// valid/ready handshake while idle. A load command writes a clamped BCD value. A count
// command steps the digit chain one count per clock, N times, in the requested direction.
// Stepping may be paused with hold_i. Completion is signalled with a one-cycle done pulse.
// A full wrap (all-9 to all-0, or all-0 to all-9) produces a one-cycle wrap pulse.
//
// Ports
//   clk_i           rising-edge clock
//   rst_i           synchronous, active-high reset
//   cmd_valid_i     command present
//   cmd_ready_o     high while idle (decoded from state)
//   cmd_load_i      1 = load command, 0 = count command
//   cmd_dir_i       count direction, 1 = up, 0 = down
//   cmd_steps_i     number of steps for a count command
//   cmd_load_val_i  BCD value for a load command, digit [3:0] least significant
//   hold_i          pause stepping while running
//   count_o         current BCD value
//   up_down_o       direction of the last accepted count command
//   busy_o          high while stepping
//   done_o          one-cycle completion pulse
//   wrap_o          one-cycle full-wrap pulse

module bcd_count_sequencer #(
    parameter int unsigned DIGITS = 2,
    parameter int unsigned STEP_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_load_i,
    input  logic                  cmd_dir_i,
    input  logic [STEP_W-1:0]     cmd_steps_i,
    input  logic [4*DIGITS-1:0]   cmd_load_val_i,
    input  logic                  hold_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic                  up_down_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  wrap_o
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e                state_q;
    logic [4*DIGITS-1:0]   count_q;
    logic [STEP_W-1:0]     remaining_q;
    logic                  up_down_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  wrap_q;

    // Next count value for a single step, and whether that step wraps the whole chain.
    logic [4*DIGITS-1:0]   step_val;
    logic                  step_wrap;
    logic                  carry;
    logic [3:0]            digit;

    // Load value with every digit limited to 0..9.
    logic [4*DIGITS-1:0]   load_val;

    // Ripple carry/borrow: a digit only moves while every lower digit rolled over. A carry
    // that survives past the top digit means every digit rolled over, i.e. a full wrap.
    always_comb begin
        step_val = count_q;
        carry    = 1'b1;
        digit    = 4'd0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            digit = count_q[4*i +: 4];
            if (carry) begin
                if (up_down_q) begin
                    if (digit >= 4'd9) begin
                        step_val[4*i +: 4] = 4'd0;
                    end else begin
                        step_val[4*i +: 4] = digit + 4'd1;
                        carry              = 1'b0;
                    end
                end else begin
                    if (digit == 4'd0) begin
                        step_val[4*i +: 4] = 4'd9;
                    end else begin
                        step_val[4*i +: 4] = digit - 4'd1;
                        carry              = 1'b0;
                    end
                end
            end
        end
        step_wrap = carry;
    end

    always_comb begin
        load_val = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (cmd_load_val_i[4*i +: 4] > 4'd9) begin
                load_val[4*i +: 4] = 4'd9;
            end else begin
                load_val[4*i +: 4] = cmd_load_val_i[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            count_q     <= '0;
            remaining_q <= '0;
            up_down_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            // Pulses default low; only the transitions below raise them.
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (cmd_valid_i) begin
                        if (cmd_load_i) begin
                            count_q <= load_val;
                            state_q <= StDone;
                            done_q  <= 1'b1;
                        end else begin
                            up_down_q   <= cmd_dir_i;
                            remaining_q <= cmd_steps_i;
                            if (cmd_steps_i == '0) begin
                                state_q <= StDone;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= StRun;
                                busy_q  <= 1'b1;
                            end
                        end
                    end
                end
                StRun: begin
                    if (!hold_i) begin
                        count_q     <= step_val;
                        wrap_q      <= step_wrap;
                        remaining_q <= remaining_q - STEP_W'(1);
                        if (remaining_q == STEP_W'(1)) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready_o = (state_q == StIdle);
    assign count_o     = count_q;
    assign up_down_o   = up_down_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign wrap_o      = wrap_q;

endmodule

// File: tb/tb_bcd_count_sequencer.sv
module tb_bcd_count_sequencer;

    localparam int unsigned DIGITS = 2;
    localparam int unsigned STEP_W = 8;
    localparam int unsigned CW     = 4 * DIGITS;
    localparam int          MODV   = 100;  // 10**DIGITS

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_load = 1'b0;
    logic              cmd_dir = 1'b0;
    logic [STEP_W-1:0] cmd_steps = '0;
    logic [CW-1:0]     cmd_load_val = '0;
    logic              hold = 1'b0;
    logic [CW-1:0]     count;
    logic              up_down;
    logic              busy;
    logic              done;
    logic              wrap;

    bcd_count_sequencer #(
        .DIGITS (DIGITS),
        .STEP_W (STEP_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .cmd_valid_i    (cmd_valid),
        .cmd_ready_o    (cmd_ready),
        .cmd_load_i     (cmd_load),
        .cmd_dir_i      (cmd_dir),
        .cmd_steps_i    (cmd_steps),
        .cmd_load_val_i (cmd_load_val),
        .hold_i         (hold),
        .count_o        (count),
        .up_down_o      (up_down),
        .busy_o         (busy),
        .done_o         (done),
        .wrap_o         (wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] val;
        logic          wrap;
    } step_t;

    typedef struct {
        logic [CW-1:0] val;
        logic          ud;
        int            busy_cycles;
        int            rlow_cycles;
        int            wraps;
    } cmd_t;

    step_t step_q[$];
    cmd_t  cmd_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: the counter as a plain integer modulo 10**DIGITS.
    int   model_v  = 0;
    logic model_ud = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [CW-1:0] to_bcd(input int v);
        logic [CW-1:0] r;
        int            x;
        r = '0;
        x = v;
        for (int i = 0; i < int'(DIGITS); i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_to_int(input logic [CW-1:0] b);
        int r;
        int w;
        int d;
        r = 0;
        w = 1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            d = int'(b[4*i +: 4]);
            if (d > 9) d = 9;
            r = r + d * w;
            w = w * 10;
        end
        return r;
    endfunction

    // ---------------- monitor ----------------
    logic          rst_at_edge = 1'b0;
    logic [CW-1:0] prev_count;
    logic          prev_done = 1'b0;
    int            busy_cnt = 0;
    int            rlow_cnt = 0;
    int            wrap_cnt = 0;

    always @(posedge clk) rst_at_edge <= rst;

    initial begin
        step_t s;
        cmd_t  c;
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                check("reset_count", 32'(count), 32'(0));
                check("reset_up_down", 32'(up_down), 32'(1));
                check("reset_busy", 32'(busy), 32'(0));
                check("reset_done", 32'(done), 32'(0));
                check("reset_wrap", 32'(wrap), 32'(0));
                check("reset_ready", 32'(cmd_ready), 32'(1));
                busy_cnt   = 0;
                rlow_cnt   = 0;
                wrap_cnt   = 0;
                prev_done  = 1'b0;
                prev_count = count;
            end else begin
                if (busy) busy_cnt++;
                if (!cmd_ready) rlow_cnt++;
                if (wrap) wrap_cnt++;
                if (count !== prev_count) begin
                    if (step_q.size() == 0) begin
                        check("unexpected_count_change", 32'(count), 32'(prev_count));
                    end else begin
                        s = step_q.pop_front();
                        check("step_count", 32'(count), 32'(s.val));
                        check("step_wrap", 32'(wrap), 32'(s.wrap));
                    end
                end
                prev_count = count;
                if (done) begin
                    check("done_single_cycle", 32'(prev_done), 32'(0));
                    if (cmd_q.size() == 0) begin
                        check("unexpected_done", 32'(done), 32'(0));
                    end else begin
                        c = cmd_q.pop_front();
                        check("final_count", 32'(count), 32'(c.val));
                        check("final_up_down", 32'(up_down), 32'(c.ud));
                        check("busy_cycles", 32'(busy_cnt), 32'(c.busy_cycles));
                        check("ready_low_cycles", 32'(rlow_cnt), 32'(c.rlow_cycles));
                        check("wrap_pulses", 32'(wrap_cnt), 32'(c.wraps));
                    end
                    busy_cnt = 0;
                    rlow_cnt = 0;
                    wrap_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    // ---------------- driver ----------------
    task automatic wait_ready();
        int t;
        t = 0;
        while (!cmd_ready && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (!cmd_ready) begin
            n_checks++;
            $display("FAIL ready_timeout: cmd_ready still low after %0d cycles", t);
        end
    endtask

    task automatic issue(input bit load, input bit dir, input int steps,
                         input logic [CW-1:0] lval, input int hold_k, input int hold_n,
                         input bit garbage);
        cmd_t  c;
        step_t s;
        int    h;
        int    k;
        int    nv;
        wait_ready();
        h = 0;
        k = hold_k;
        c.wraps = 0;
        if (load) begin
            nv = clamp_to_int(lval);
            if (nv != model_v) begin
                s.val  = to_bcd(nv);
                s.wrap = 1'b0;
                step_q.push_back(s);
            end
            model_v       = nv;
            c.busy_cycles = 0;
            c.rlow_cycles = 1;
        end else begin
            model_ud = dir;
            if (steps >= 2 && hold_n > 0) begin
                h = hold_n;
                if (k < 1 || k > steps - 1) k = 1;
            end
            for (int i = 0; i < steps; i++) begin
                if (dir) begin
                    s.wrap  = (model_v == MODV - 1);
                    model_v = (model_v + 1) % MODV;
                end else begin
                    s.wrap  = (model_v == 0);
                    model_v = (model_v + MODV - 1) % MODV;
                end
                s.val = to_bcd(model_v);
                if (s.wrap) c.wraps++;
                step_q.push_back(s);
            end
            c.busy_cycles = steps + h;
            c.rlow_cycles = (steps == 0) ? 1 : steps + h + 1;
        end
        c.val = to_bcd(model_v);
        c.ud  = model_ud;
        cmd_q.push_back(c);

        cmd_valid    = 1'b1;
        cmd_load     = load;
        cmd_dir      = dir;
        cmd_steps    = STEP_W'(steps);
        cmd_load_val = lval;
        // hold outside RUN must have no effect
        hold         = (load || steps == 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        #1;
        cmd_valid = 1'b0;
        hold      = 1'b0;
        if (garbage) begin
            cmd_valid    = 1'b1;
            cmd_load     = 1'($urandom_range(0, 1));
            cmd_dir      = 1'($urandom_range(0, 1));
            cmd_steps    = STEP_W'($urandom_range(0, 20));
            cmd_load_val = CW'($urandom);
        end
        @(negedge clk);
        #1;
        cmd_valid = 1'b0;
        if (h > 0) begin
            repeat (k - 1) @(negedge clk);
            #1;
            hold = 1'b1;
            repeat (h) @(negedge clk);
            #1;
            hold = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        step_q.delete();
        cmd_q.delete();
        model_v  = 0;
        model_ud = 1'b1;
        rst      = 1'b1;
        @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int t;
        int n;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;

        issue(1'b0, 1'b1, 12, '0, 0, 0, 1'b0);           // up 12 from 0
        issue(1'b1, 1'b0, 0, CW'(8'h98), 0, 0, 1'b0);    // load 0x98
        issue(1'b0, 1'b1, 3, '0, 0, 0, 1'b0);            // up wrap
        issue(1'b1, 1'b0, 0, CW'(8'h01), 0, 0, 1'b0);    // load 0x01
        issue(1'b0, 1'b0, 3, '0, 0, 0, 1'b0);            // down wrap
        issue(1'b1, 1'b0, 0, CW'(8'hA5), 0, 0, 1'b1);    // clamp to 0x95
        issue(1'b1, 1'b0, 0, CW'(8'h00), 0, 0, 1'b0);
        issue(1'b0, 1'b1, 5, '0, 2, 3, 1'b0);            // hold 3 mid-run
        issue(1'b0, 1'b0, 0, '0, 0, 0, 1'b1);            // zero steps
        issue(1'b0, 1'b1, 6, '0, 0, 0, 1'b1);            // valid pulsed during RUN

        // Reset mid-run: pending steps and completion are discarded.
        issue(1'b0, 1'b1, 20, '0, 0, 0, 1'b0);
        repeat (4) @(negedge clk);
        do_reset();

        for (int i = 0; i < 40; i++) begin
            n = $urandom_range(0, 3) == 0 ? 0 : $urandom_range(1, 30);
            issue(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), n,
                  CW'($urandom), $urandom_range(1, 29), $urandom_range(0, 1) * $urandom_range(1, 4),
                  1'($urandom_range(0, 1)));
        end

        t = 0;
        while ((cmd_q.size() != 0 || !cmd_ready) && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
        end
        repeat (3) @(negedge clk);
        check("pending_commands", 32'(cmd_q.size()), 32'(0));
        check("pending_steps", 32'(step_q.size()), 32'(0));
        check("idle_final", 32'(cmd_ready), 32'(1));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
